// File: rtl/bcmac_pkg.sv
// Shared definitions for the bit-serial MAC column and its downstream consumers.
package bcmac_pkg;

    localparam int unsigned DEF_BITS  = 8;
    localparam int unsigned DEF_ACC_W = 20;
    localparam int unsigned ST_W      = 2;
    localparam int unsigned LEN_W     = 8;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_SHIFT = 2'd1;
    localparam logic [ST_W-1:0] ST_ADD   = 2'd2;
    localparam logic [ST_W-1:0] ST_HOLD  = 2'd3;

    // Width of a bit counter that indexes positions 0..bits-1.
    function automatic int unsigned cnt_width(input int unsigned bits);
        return (bits <= 1) ? 1 : $clog2(bits);
    endfunction

endpackage

// File: rtl/bitserial_deser.sv
// LSB-first deserializer: assembles one word, restarts on a mid-word frame_start.
module bitserial_deser
    import bcmac_pkg::*;
#(
    parameter int unsigned BITS = DEF_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bit_i,
    input  logic            accept_i,
    input  logic            frame_start_i,
    output logic [BITS-1:0] word_o,
    output logic            word_done_c_o,
    output logic            frame_err_o
);

    localparam int unsigned CNT_W = cnt_width(BITS);

    logic [BITS-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ferr_q, ferr_d;

    // A non-zero bit counter means a word is in progress.
    always_comb begin
        sr_d          = sr_q;
        cnt_d         = cnt_q;
        ferr_d        = 1'b0;
        word_done_c_o = 1'b0;
        if (accept_i) begin
            if (frame_start_i) begin
                sr_d   = BITS'(bit_i);
                cnt_d  = CNT_W'(1);
                ferr_d = (cnt_q != '0);
            end else if (cnt_q != '0) begin
                sr_d[cnt_q] = bit_i;
                if (cnt_q == CNT_W'(BITS - 1)) begin
                    cnt_d         = '0;
                    word_done_c_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            ferr_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            ferr_q <= ferr_d;
        end
    end

    assign word_o      = sr_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/bitserial_accum.sv
// Collects serial words from the bitblock chain and accumulates a programmable
// number of them into a wide result offered on a valid/ready port.
module bitserial_accum
    import bcmac_pkg::*;
#(
    parameter int unsigned BITS   = DEF_BITS,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter bit          SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic             in_ready,
    input  logic [LEN_W-1:0] acc_len,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             frame_err
);

    logic [ST_W-1:0]  state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] wcnt_q, wcnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             accept_c;
    logic [BITS-1:0]  word_c;
    logic             word_done_c;
    logic [ACC_W-1:0] ext_c;
    logic [ACC_W:0]   sum_c;
    logic             ovf_now_c;
    logic [LEN_W-1:0] wcnt_inc_c;
    logic [LEN_W-1:0] len_eff_c;

    assign accept_c = bit_valid && in_ready_q;

    bitserial_deser #(.BITS(BITS)) u_deser (
        .clk           (clk),
        .rst           (rst),
        .bit_i         (bit_in),
        .accept_i      (accept_c),
        .frame_start_i (frame_start),
        .word_o        (word_c),
        .word_done_c_o (word_done_c),
        .frame_err_o   (frame_err)
    );

    // Sign- or zero-extend the assembled word to the accumulator width.
    always_comb begin
        ext_c = ACC_W'(word_c);
        if (SIGNED && word_c[BITS-1]) begin
            for (int unsigned i = BITS; i < ACC_W; i++) begin
                ext_c[i] = 1'b1;
            end
        end
    end

    assign sum_c      = {1'b0, acc_q} + {1'b0, ext_c};
    assign ovf_now_c  = SIGNED ? ((acc_q[ACC_W-1] == ext_c[ACC_W-1]) &&
                                  (sum_c[ACC_W-1] != acc_q[ACC_W-1]))
                               : sum_c[ACC_W];
    assign wcnt_inc_c = wcnt_q + LEN_W'(1);
    assign len_eff_c  = (len_q == '0) ? LEN_W'(1) : len_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (wcnt_q == '0) begin
                    len_d = acc_len;
                end
                if (accept_c && frame_start) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (word_done_c) begin
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                acc_d   = sum_c[ACC_W-1:0];
                ovf_d   = ovf_q | ovf_now_c;
                wcnt_d  = wcnt_inc_c;
                state_d = (wcnt_inc_c == len_eff_c) ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    wcnt_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_SHIFT);
        out_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            wcnt_q      <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wcnt_q      <= wcnt_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_bitserial_accum.sv
// Randomized bench for bitserial_accum: two instances (wide and narrow
// accumulator) share stimulus and are compared against an arithmetic model.
module tb_bitserial_accum;

    localparam int unsigned BITS = 8;
    localparam int unsigned W_A  = 20;
    localparam int unsigned W_B  = 9;

    logic           clk = 1'b0;
    logic           rst;
    logic           bit_in;
    logic           bit_valid;
    logic           frame_start;
    logic           out_ready;
    logic [7:0]     acc_len;

    logic           in_ready_a, out_valid_a, overflow_a, frame_err_a;
    logic [W_A-1:0] acc_out_a;
    logic           in_ready_b, out_valid_b, overflow_b, frame_err_b;
    logic [W_B-1:0] acc_out_b;

    int n_checks = 0;
    int n_errors = 0;
    int wq[$];

    always #5 clk = ~clk;

    bitserial_accum #(.BITS(BITS), .ACC_W(W_A), .SIGNED(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .in_ready(in_ready_a), .acc_len(acc_len),
        .acc_out(acc_out_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .overflow(overflow_a), .frame_err(frame_err_a)
    );

    bitserial_accum #(.BITS(BITS), .ACC_W(W_B), .SIGNED(1'b1)) dut_b (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .in_ready(in_ready_b), .acc_len(acc_len),
        .acc_out(acc_out_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .overflow(overflow_b), .frame_err(frame_err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int to_signed(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Exact-integer model: sum words one at a time, flag any result outside the signed range.
    function automatic void ref_sum(input int words[$], input int w, output int acc, output bit ovf);
        longint m;
        longint a;
        longint sa;
        longint s;
        m   = 64'sd1 <<< w;
        a   = 0;
        ovf = 1'b0;
        foreach (words[i]) begin
            sa = (a >= m / 2) ? a - m : a;
            s  = sa + longint'(to_signed(words[i]));
            if (s < -(m / 2) || s > (m / 2) - 1) ovf = 1'b1;
            a = ((s % m) + m) % m;
        end
        acc = int'(a);
    endfunction

    task automatic send_word(input int v, input int max_gap, input bit scramble);
        for (int i = 0; i < int'(BITS); i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                bit_valid   = 1'b0;
                bit_in      = 1'($urandom);
                frame_start = 1'($urandom);
                tick();
            end
            bit_valid   = 1'b1;
            bit_in      = v[i];
            frame_start = (i == 0);
            tick();
            if (i == 0 && scramble) acc_len = 8'($urandom_range(0, 255));
        end
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic run_result(input string name, input int words[$], input int len_field,
                              input int max_gap, input int hold_cycles);
        int             exp_a, exp_b;
        bit             ovf_a, ovf_b;
        logic [W_A-1:0] held;
        ref_sum(words, W_A, exp_a, ovf_a);
        ref_sum(words, W_B, exp_b, ovf_b);
        acc_len = 8'(len_field);
        foreach (words[k]) begin
            send_word(words[k], max_gap, k == 0);
            if (k != words.size() - 1) tick();
        end
        check({name, ".add_in_ready"}, 32'(in_ready_a), 32'd0);
        check({name, ".add_valid"}, 32'(out_valid_a), 32'd0);
        if (hold_cycles == 0) out_ready = 1'b1;
        tick();
        check({name, ".valid"}, 32'(out_valid_a), 32'd1);
        check({name, ".valid_b"}, 32'(out_valid_b), 32'd1);
        check({name, ".acc_a"}, 32'(acc_out_a), 32'(exp_a));
        check({name, ".acc_b"}, 32'(acc_out_b), 32'(exp_b));
        check({name, ".ovf_a"}, 32'(overflow_a), 32'(ovf_a));
        check({name, ".ovf_b"}, 32'(overflow_b), 32'(ovf_b));
        held = acc_out_a;
        for (int c = 0; c < hold_cycles; c++) begin
            bit_valid   = 1'b1;
            bit_in      = 1'($urandom);
            frame_start = 1'($urandom);
            tick();
            check({name, ".bp_in_ready"}, 32'(in_ready_a), 32'd0);
            check({name, ".bp_valid"}, 32'(out_valid_a), 32'd1);
            check({name, ".bp_acc"}, 32'(acc_out_a), 32'(held));
        end
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        out_ready   = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, ".hs_valid"}, 32'(out_valid_a), 32'd0);
        check({name, ".hs_in_ready"}, 32'(in_ready_a), 32'd1);
        check({name, ".hs_acc"}, 32'(acc_out_a), 32'd0);
        check({name, ".hs_ovf_b"}, 32'(overflow_b), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int fe_junk;
        int fe_word;
        int rst_word;
        int len;
        int n;

        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
        out_ready = 1'b0; acc_len = 8'd0;
        tick();
        tick();
        check("rst.in_ready", 32'(in_ready_a), 32'd1);
        check("rst.valid", 32'(out_valid_a), 32'd0);
        check("rst.acc", 32'(acc_out_a), 32'd0);
        check("rst.ovf", 32'(overflow_a), 32'd0);
        check("rst.ferr", 32'(frame_err_a), 32'd0);
        rst = 1'b0;
        tick();

        wq.delete(); wq.push_back(8'h05);
        run_result("single", wq, 1, 0, 0);

        wq.delete(); wq.push_back(8'h7F); wq.push_back(8'h80); wq.push_back(8'h01);
        run_result("signed", wq, 3, 3, 0);

        wq.delete(); wq.push_back(8'h33); wq.push_back(8'h44);
        run_result("bp", wq, 2, 1, 5);
        wq.delete(); wq.push_back(8'h09);
        run_result("after_bp", wq, 1, 0, 0);

        // Frame restart three bits into a word; only the restarted word counts.
        fe_junk = 8'hFF;
        fe_word = 8'h12;
        acc_len = 8'd1;
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1; bit_in = fe_junk[i]; frame_start = (i == 0);
            tick();
            if (i == 0) check("ferr.idle_start", 32'(frame_err_a), 32'd0);
        end
        for (int i = 0; i < int'(BITS); i++) begin
            bit_valid = 1'b1; bit_in = fe_word[i]; frame_start = (i == 0);
            tick();
            if (i == 0) check("ferr.pulse", 32'(frame_err_a), 32'd1);
            if (i == 1) check("ferr.one_cycle", 32'(frame_err_a), 32'd0);
        end
        bit_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b1;
        tick();
        check("ferr.valid", 32'(out_valid_a), 32'd1);
        check("ferr.acc", 32'(acc_out_a), 32'h12);
        tick();
        out_ready = 1'b0;
        check("ferr.hs_valid", 32'(out_valid_a), 32'd0);

        wq.delete(); wq.push_back(8'h7F); wq.push_back(8'h7F); wq.push_back(8'h7F);
        run_result("ovf", wq, 3, 1, 2);

        wq.delete(); wq.push_back(8'hFE);
        run_result("len0", wq, 0, 0, 0);

        // Reset after bit 4 of the second word of a two-word result.
        acc_len = 8'd2;
        send_word(8'h11, 0, 1'b0);
        tick();
        rst_word = 8'h22;
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1; bit_in = rst_word[i]; frame_start = (i == 0);
            tick();
        end
        bit_valid = 1'b0; frame_start = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst.in_ready", 32'(in_ready_a), 32'd1);
        check("mrst.valid", 32'(out_valid_a), 32'd0);
        check("mrst.acc", 32'(acc_out_a), 32'd0);
        check("mrst.ovf", 32'(overflow_a), 32'd0);
        check("mrst.ferr", 32'(frame_err_a), 32'd0);
        wq.delete(); wq.push_back(8'h03);
        run_result("after_rst", wq, 1, 0, 0);

        for (int r = 0; r < 30; r++) begin
            len = $urandom_range(0, 4);
            n   = (len == 0) ? 1 : len;
            wq.delete();
            for (int k = 0; k < n; k++) wq.push_back(int'($urandom_range(0, 255)));
            run_result($sformatf("rand%0d", r), wq, len, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
